// File: rtl/comparador_nbit_serial_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding
// and counter sizing helper.
package comparador_nbit_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned N_DEFAULT = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparador_nbit_serial_if.sv
// Operand/handshake bundle between a requester (master) and the
// bit-serial comparator (slave).
interface comparador_nbit_serial_if #(
    parameter int unsigned N = 8
);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt
    );

endinterface

// File: rtl/comparador_nbit_serial_celda.sv
// Single-bit comparison stage: once eq_in drops, the stage can no longer
// raise a new gt/lt, so the first differing bit decides the result.
module comparador_celda (
    input  logic a_bit,
    input  logic b_bit,
    input  logic eq_in,
    output logic eq_out,
    output logic gt_out,
    output logic lt_out
);

    always_comb begin
        eq_out = eq_in & ~(a_bit ^ b_bit);
        gt_out = eq_in &  a_bit & ~b_bit;
        lt_out = eq_in & ~a_bit &  b_bit;
    end

endmodule

// File: rtl/comparador_nbit_serial.sv
// Bit-serial unsigned N-bit comparator, MSB first, busy/done handshake.
// Define COMPARADOR_EARLY_EXIT_EN to finish on the first differing bit.
module comparador_nbit_serial
    import comparador_nbit_serial_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input logic                     clk,
    input logic                     rst,
    comparador_nbit_serial_if.slave bus
);

    localparam int unsigned CW = cnt_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sh_a;
    logic [N-1:0]  sh_b;
    logic [CW-1:0] cnt;
    logic          eq_acc;
    logic          gt_acc;
    logic          lt_acc;
    logic          res_eq;
    logic          res_gt;
    logic          res_lt;
    logic          cell_eq;
    logic          cell_gt;
    logic          cell_lt;
    logic          accept;
    logic          finish;
    logic          gt_nxt;
    logic          lt_nxt;

    comparador_celda u_celda (
        .a_bit  (sh_a[N-1]),
        .b_bit  (sh_b[N-1]),
        .eq_in  (eq_acc),
        .eq_out (cell_eq),
        .gt_out (cell_gt),
        .lt_out (cell_lt)
    );

    always_comb begin
        accept    = 1'b0;
        finish    = 1'b0;
        state_nxt = state;
        gt_nxt    = gt_acc | cell_gt;
        lt_nxt    = lt_acc | cell_lt;

        case (state)
            ST_IDLE: begin
                accept = bus.start;
                if (bus.start)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
`ifdef COMPARADOR_EARLY_EXIT_EN
                // A dropping eq_acc marks the deciding bit; later bits are irrelevant.
                finish = (cnt == CW'(N - 1)) || (eq_acc && !cell_eq);
`else
                finish = (cnt == CW'(N - 1));
`endif
                if (finish)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                accept    = bus.start;
                state_nxt = bus.start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            eq_acc <= 1'b0;
            gt_acc <= 1'b0;
            lt_acc <= 1'b0;
            res_eq <= 1'b0;
            res_gt <= 1'b0;
            res_lt <= 1'b0;
        end else if (accept) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            cnt    <= '0;
            eq_acc <= 1'b1;
            gt_acc <= 1'b0;
            lt_acc <= 1'b0;
            res_eq <= 1'b0;
            res_gt <= 1'b0;
            res_lt <= 1'b0;
        end else if (state == ST_RUN) begin
            sh_a   <= {sh_a[N-2:0], 1'b0};
            sh_b   <= {sh_b[N-2:0], 1'b0};
            eq_acc <= cell_eq;
            gt_acc <= gt_nxt;
            lt_acc <= lt_nxt;
            if (finish) begin
                res_eq <= cell_eq;
                res_gt <= gt_nxt;
                res_lt <= lt_nxt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
    assign bus.eq   = res_eq;
    assign bus.gt   = res_gt;
    assign bus.lt   = res_lt;

endmodule

// File: tb/tb_comparador_nbit_serial.sv
// Self-checking bench for comparador_nbit_serial: directed and random
// comparisons against an arithmetic reference model.
module tb_comparador_nbit_serial;

    localparam int N = 8;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    comparador_nbit_serial_if #(.N(N)) bus ();

    comparador_nbit_serial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one compare (caller is #1 after an edge, DUT idle or in its done
    // cycle) and check every cycle up to the done pulse. With b2b set, return
    // inside the done cycle so the next call starts there.
    task automatic run_compare(input logic [N-1:0] ta, input logic [N-1:0] tb,
                               input bit intrude, input bit b2b);
        int           lat;
        logic [N-1:0] x;
        logic [4:0]   got;
        logic [4:0]   exp;
        logic         e_eq;
        logic         e_gt;
        logic         e_lt;
        e_eq = (ta == tb);
        e_gt = (ta > tb);
        e_lt = (ta < tb);
        lat  = N + 1;
        x    = ta ^ tb;
`ifdef COMPARADOR_EARLY_EXIT_EN
        for (int i = 0; i < N; i++)
            if (x[i]) lat = N - i + 1;
`endif
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < lat; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            got = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt};
            exp = (j < lat - 1) ? 5'b10000 : {2'b01, e_eq, e_gt, e_lt};
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL run a=%h b=%h cycle=%0d busy,done,eq,gt,lt got=%b expected=%b",
                         ta, tb, j, got, exp);
            end
            if (intrude && j < lat - 1) begin
                bus.start = (j == 1);
                bus.a     = (j == 1) ? '1 : N'($urandom);
                bus.b     = (j == 1) ? '1 : N'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!b2b) begin
            @(posedge clk); #1;
            got = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt};
            exp = {2'b00, e_eq, e_gt, e_lt};
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL hold a=%h b=%h busy,done,eq,gt,lt got=%b expected=%b",
                         ta, tb, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) begin
            @(posedge clk); #1;
            got = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt};
            tests++;
            if (got !== 5'b00000) begin
                failed++;
                $display("FAIL reset outputs got=%b expected=00000", got);
            end
        end
        rst = 1'b0;
        run_compare(8'h3C, 8'h3B, 1'b0, 1'b0);
    endtask

    task automatic test_directed();
        run_compare(8'h5A, 8'h5A, 1'b0, 1'b0);
        run_compare(8'h80, 8'h7F, 1'b0, 1'b0);
        run_compare(8'h01, 8'h02, 1'b0, 1'b0);
        run_compare(8'h00, 8'hFF, 1'b0, 1'b0);
        run_compare(8'hFF, 8'h00, 1'b0, 1'b0);
        run_compare(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_compare(8'h10, 8'h20, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_compare(8'h10, 8'h20, 1'b0, 1'b1);
        run_compare(8'hFF, 8'hFF, 1'b0, 1'b1);
        run_compare(8'hA5, 8'hA4, 1'b0, 1'b0);
    endtask

    task automatic test_reset_in_run();
        logic [4:0] got;
        bus.start = 1'b1;
        bus.a     = 8'h33;
        bus.b     = 8'h33;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            got = {bus.busy, bus.done, bus.eq, bus.gt, bus.lt};
            tests++;
            if (got !== 5'b00000) begin
                failed++;
                $display("FAIL abort cycle=%0d busy,done,eq,gt,lt got=%b expected=00000", c, got);
            end
            @(posedge clk); #1;
        end
        run_compare(8'hFF, 8'hFE, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        bit           chain;
        for (int k = 0; k < 40; k++) begin
            ra    = N'($urandom);
            rb    = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
            chain = (k < 39) && ($urandom_range(0, 1) == 1);
            run_compare(ra, rb, ($urandom_range(0, 7) == 0), chain);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_in_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
